fir_decimator: RTL and testbench
================================

# fir_decimator

Downstream stage of the FIR filter top entity. It takes the filter's 16-bit signed output stream, boxcar-averages each block of DECIM consecutive samples into one decimated sample, and buffers the results in a small FIFO. The FIFO drains through a valid/ready handshake to the next consumer, such as a serializer or bus bridge. The block has one clock domain, its own overflow detection and occupancy reporting.

## Interface
- WIDTH, 16, sample width in bits, signed two's complement; must match the FIR output width.
- DECIM, 4, decimation factor; must be a power of 2, 1..64.
- DEPTH, 4, FIFO depth in entries; must be a power of 2, ≥2.
- LOG2D, derived, log2(DECIM); not user-set.
- system1000  in  1  clock; all logic is rising-edge.
- system1000_rst  in  1  reset, synchronous, active-high.
- sample_in  in  WIDTH  signed sample; connected to the FIR `result` output.
- sample_en  in  1  sample_in is valid this cycle. Tie high when the FIR produces a sample every clock.
- out_data  out  WIDTH  signed decimated sample at the FIFO head.
- out_valid  out  1  FIFO non-empty; out_data is meaningful.
- out_ready  in  1  consumer accepts out_data this cycle.
- fill  out  clog2(DEPTH+1)  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky; set when a decimated sample was dropped.

## Operation
- **Accumulator.**
  - Width is WIDTH+LOG2D, signed.
  - The phase counter has range 0..DECIM-1.
  - On each cycle with sample_en=1, sample_in (sign-extended) is added.
  - At phase 0 the accumulator loads sample_in instead of adding to the previous value.
  - When sample_en=0, phase and accumulator hold.
- **Block completion.**
  - A block completes on a cycle with sample_en=1 and phase=DECIM-1.
  - Result = (acc + sample_in) >>> LOG2D, an arithmetic shift that floors toward −∞.
  - No saturation is needed: the result always fits in WIDTH.
  - Phase wraps to 0 on completion.
- **DECIM=1.** Every enabled sample is pushed unchanged.
- **FIFO.** Circular buffer of DEPTH entries with read/write pointers and a count register.
  - push = block completion.
  - pop = out_valid & out_ready.
  - A push is accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave count unchanged. This applies at full and at 1 entry.
  - A push while full with no pop is dropped. The stored data is unchanged, and overflow is set and held until reset.
  - A pop while empty cannot occur, because out_valid=0.
- **Outputs.**
  - out_valid = (count≠0).
  - out_data = head entry when out_valid=1, else 0.
  - fill = count.
  - out_data must stay stable while out_valid=1 and out_ready=0.
- **Reset** (any cycle, including mid-block or with FIFO data present) clears:
  - phase, accumulator, pointers, count and overflow;
  - any partial block, which is discarded;
  - any FIFO contents, which are lost.
- **Reset values:** out_data=0, out_valid=0, fill=0, overflow=0.

## Timing
- Latency: completion edge at cycle t gives out_valid=1 and out_data=result in cycle t+1, when the FIFO was empty and there was no pop in cycle t.
- Pop takes effect at the clock edge. The next entry, or out_valid=0, is visible in the following cycle.
- Maximum sustained input rate is one sample per clock. Output rate is input rate / DECIM.
- Reset is sampled at the rising edge. Outputs hold reset values in the cycle after any edge with system1000_rst=1.
- sample_en and out_ready are ignored while reset is asserted.
- There is no combinational path from sample_in/sample_en to any output. out_valid and out_data depend only on registers.

## Test plan
- **Basic average.** DECIM=4, out_ready=1, samples 100, 200, 300, 400 on consecutive cycles → out_valid for exactly one cycle, one cycle after the 4th sample, with out_data=250.
- **Negative rounding.** Samples −1, −1, −1, −2 → out_data=−2 (floor of −1.25). Samples 32767×4 → 32767. Samples −32768×4 → −32768.
- **Gapped enable.** Samples 10, 20, 30, 40 with sample_en low for 3 cycles between each → single output 25. No output during the gaps.
- **Backpressure and overflow.** DEPTH=4, out_ready=0, 5 full blocks of constant values 1, 2, 3, 4, 5 → fill=4 and overflow=1 after the 5th block. Then raise out_ready → outputs 1, 2, 3, 4 on consecutive cycles, fill counts down to 0, overflow stays 1.
- **Full with simultaneous push and pop.** FIFO full with out_ready=1 in the same cycle as a completion → no drop, overflow stays 0, fill stays 4, output order preserved.
- **Mid-block reset.** Feed 2 samples of 1000, assert system1000_rst for 1 cycle, then feed 8, 8, 8, 8 → only output is 8; fill, out_valid and overflow are 0 immediately after the reset edge.

Source files
------------

// File: rtl/fir_decimator.sv
// Boxcar decimator behind the FIR: averages DECIM enabled samples per block
// and queues the results in a small FIFO drained by a valid/ready handshake.
module fir_decimator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DECIM = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                             system1000,
    input  logic                             system1000_rst,
    input  logic signed [WIDTH-1:0]          sample_in,
    input  logic                             sample_en,
    output logic signed [WIDTH-1:0]          out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(DEPTH+1)-1:0]       fill,
    output logic                             overflow
);

    localparam int unsigned LOG2D  = $clog2(DECIM);
    localparam int unsigned AW     = WIDTH + LOG2D;
    localparam int unsigned PW     = (LOG2D > 0) ? LOG2D : 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);

    logic        [PW-1:0]     phase_q;
    logic signed [AW-1:0]     acc_q;
    logic signed [AW-1:0]     acc_base_c;
    logic signed [AW-1:0]     sum_c;
    logic signed [WIDTH-1:0]  result_c;
    logic                     complete_c;

    logic signed [WIDTH-1:0]  mem_q [DEPTH];
    logic        [PTR_W-1:0]  wr_q;
    logic        [PTR_W-1:0]  rd_q;
    logic        [PTR_W-1:0]  rd_next_c;
    logic        [FILL_W-1:0] count_q;
    logic        [FILL_W-1:0] count_next_c;
    logic signed [WIDTH-1:0]  head_next_c;
    logic                     pop_c;
    logic                     push_c;
    logic                     drop_c;
    logic                     full_c;

    // Block sum; phase 0 starts a fresh block instead of accumulating.
    always_comb begin
        acc_base_c = '0;
        if (phase_q != '0) begin
            acc_base_c = acc_q;
        end
        sum_c      = acc_base_c + AW'(sample_in);
        complete_c = sample_en && (phase_q == PW'(DECIM - 1));
        result_c   = WIDTH'(sum_c >>> LOG2D);
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            phase_q <= '0;
            acc_q   <= '0;
        end else if (sample_en) begin
            acc_q   <= sum_c;
            phase_q <= complete_c ? '0 : phase_q + PW'(1);
        end
    end

    // FIFO control; the head register is precomputed so out_data is a flop.
    always_comb begin
        pop_c        = out_valid && out_ready;
        full_c       = (count_q == FILL_W'(DEPTH));
        push_c       = complete_c && (!full_c || pop_c);
        drop_c       = complete_c && full_c && !pop_c;
        rd_next_c    = pop_c ? rd_q + PTR_W'(1) : rd_q;
        count_next_c = count_q + FILL_W'(push_c) - FILL_W'(pop_c);
        head_next_c  = '0;
        if (count_next_c != '0) begin
            if (push_c && (wr_q == rd_next_c)) begin
                head_next_c = result_c;
            end else begin
                head_next_c = mem_q[rd_next_c];
            end
        end
    end

    always_ff @(posedge system1000) begin
        if (!system1000_rst && push_c) begin
            mem_q[wr_q] <= result_c;
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push_c) begin
                wr_q <= wr_q + PTR_W'(1);
            end
            rd_q      <= rd_next_c;
            count_q   <= count_next_c;
            out_valid <= (count_next_c != '0);
            out_data  <= head_next_c;
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    assign fill = count_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Self-checking bench for fir_decimator (DECIM=4, DEPTH=4): directed table,
// hand-written corner sequences and randomized traffic against a queue model.
module tb_fir_decimator;

    logic               system1000;
    logic               system1000_rst;
    logic signed [15:0] sample_in;
    logic               sample_en;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         fill;
    logic               overflow;

    int n_checks;
    int n_errors;

    int blk[$];
    int mq[$];
    int m_ovf;

    typedef struct {
        int s0;
        int s1;
        int s2;
        int s3;
        int exp;
    } vec_t;

    vec_t vecs[6];

    fir_decimator #(.WIDTH(16), .DECIM(4), .DEPTH(4)) dut (
        .system1000     (system1000),
        .system1000_rst (system1000_rst),
        .sample_in      (sample_in),
        .sample_en      (sample_en),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fill           (fill),
        .overflow       (overflow)
    );

    initial system1000 = 1'b0;
    always #5 system1000 = ~system1000;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int floor_div4(input int s);
        int q;
        q = s / 4;
        if ((s % 4) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
    task automatic cyc(input logic rst, input int smp, input logic en, input logic rdy);
        bit pop;
        bit comp;
        int res;
        int sum;
        system1000_rst = rst;
        sample_in      = 16'(smp);
        sample_en      = en;
        out_ready      = rdy;
        @(posedge system1000);
        if (rst) begin
            blk.delete();
            mq.delete();
            m_ovf = 0;
        end else begin
            pop  = (mq.size() != 0) && rdy;
            comp = 0;
            res  = 0;
            if (en) begin
                blk.push_back(smp);
                if (blk.size() == 4) begin
                    sum = 0;
                    foreach (blk[i]) sum += blk[i];
                    res  = floor_div4(sum);
                    comp = 1;
                    blk.delete();
                end
            end
            if (pop) void'(mq.pop_front());
            if (comp) begin
                if (mq.size() < 4) mq.push_back(res);
                else m_ovf = 1;
            end
        end
        #1;
        chk("out_valid", int'(out_valid), (mq.size() != 0) ? 1 : 0);
        chk("out_data", int'(out_data), (mq.size() != 0) ? mq[0] : 0);
        chk("fill", int'(fill), mq.size());
        chk("overflow", int'(overflow), m_ovf);
    endtask

    task automatic block4(input int v, input logic rdy);
        for (int i = 0; i < 4; i++) cyc(1'b0, v, 1'b1, rdy);
    endtask

    initial begin
        logic signed [15:0] r;
        int smp;
        n_checks = 0;
        n_errors = 0;
        m_ovf    = 0;

        vecs[0] = '{s0: 100,    s1: 200,    s2: 300,    s3: 400,    exp: 250};
        vecs[1] = '{s0: -1,     s1: -1,     s2: -1,     s3: -2,     exp: -2};
        vecs[2] = '{s0: 32767,  s1: 32767,  s2: 32767,  s3: 32767,  exp: 32767};
        vecs[3] = '{s0: -32768, s1: -32768, s2: -32768, s3: -32768, exp: -32768};
        vecs[4] = '{s0: 5,      s1: 6,      s2: 7,      s3: 9,      exp: 6};
        vecs[5] = '{s0: -5,     s1: -6,     s2: -7,     s3: -9,     exp: -7};

        cyc(1'b1, 0, 1'b0, 1'b0);
        cyc(1'b1, 0, 1'b0, 1'b0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_data", int'(out_data), 0);
        chk("reset_fill", int'(fill), 0);
        chk("reset_overflow", int'(overflow), 0);

        // Directed averages: output appears exactly one cycle after the 4th sample.
        foreach (vecs[k]) begin
            cyc(1'b0, vecs[k].s0, 1'b1, 1'b1);
            cyc(1'b0, vecs[k].s1, 1'b1, 1'b1);
            cyc(1'b0, vecs[k].s2, 1'b1, 1'b1);
            chk("vec_early_valid", int'(out_valid), 0);
            cyc(1'b0, vecs[k].s3, 1'b1, 1'b1);
            chk("vec_valid", int'(out_valid), 1);
            chk("vec_data", int'(out_data), vecs[k].exp);
            cyc(1'b0, 0, 1'b0, 1'b1);
            chk("vec_one_cycle", int'(out_valid), 0);
        end

        // Gapped enable.
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b0, i * 10, 1'b1, 1'b1);
            if (i < 4) begin
                for (int g = 0; g < 3; g++) begin
                    cyc(1'b0, 777, 1'b0, 1'b1);
                    chk("gap_no_output", int'(out_valid), 0);
                end
            end
        end
        chk("gap_valid", int'(out_valid), 1);
        chk("gap_data", int'(out_data), 25);
        cyc(1'b0, 0, 1'b0, 1'b1);

        // Backpressure then overflow, then drain.
        for (int v = 1; v <= 5; v++) block4(v, 1'b0);
        chk("bp_fill", int'(fill), 4);
        chk("bp_overflow", int'(overflow), 1);
        for (int v = 1; v <= 4; v++) begin
            chk("bp_drain_data", int'(out_data), v);
            chk("bp_drain_fill", int'(fill), 5 - v);
            cyc(1'b0, 0, 1'b0, 1'b1);
        end
        chk("bp_empty", int'(out_valid), 0);
        chk("bp_overflow_sticky", int'(overflow), 1);

        // Full FIFO with push and pop on the same edge.
        cyc(1'b1, 0, 1'b0, 1'b0);
        for (int v = 11; v <= 14; v++) block4(v, 1'b0);
        chk("pp_full", int'(fill), 4);
        for (int i = 0; i < 3; i++) cyc(1'b0, 15, 1'b1, 1'b0);
        cyc(1'b0, 15, 1'b1, 1'b1);
        chk("pp_fill", int'(fill), 4);
        chk("pp_overflow", int'(overflow), 0);
        for (int v = 12; v <= 15; v++) begin
            chk("pp_order", int'(out_data), v);
            cyc(1'b0, 0, 1'b0, 1'b1);
        end
        chk("pp_empty", int'(fill), 0);

        // Mid-block reset discards the partial block.
        cyc(1'b0, 1000, 1'b1, 1'b1);
        cyc(1'b0, 1000, 1'b1, 1'b1);
        cyc(1'b1, 1000, 1'b1, 1'b1);
        chk("mr_fill", int'(fill), 0);
        chk("mr_valid", int'(out_valid), 0);
        chk("mr_overflow", int'(overflow), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8, 1'b1, 1'b1);
            chk("mr_no_stale", int'(out_valid), 0);
        end
        cyc(1'b0, 8, 1'b1, 1'b1);
        chk("mr_data", int'(out_data), 8);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("mr_single", int'(out_valid), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r   = 16'($urandom());
            smp = int'(r);
            cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, smp,
                ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) < (n < 1500 ? 3 : 8)) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
